// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 keyboard constants, FSM encoding and parity helper
//
// Purpose: common definitions for the PS/2 receive front end and the keyboard
//          decoder downstream of it.
// Contents: PS2_EXTEND / PS2_BREAK / PS2_BAT_OK byte constants, ps2_state_t
//           receive FSM encoding, odd_parity_ok() frame parity check.
package ps2_pkg;

  localparam logic [7:0] PS2_EXTEND = 8'hE0;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    CHECK  = 3'd4
  } ps2_state_t;

  // Data byte plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser, clock glitch filter and fall detect
//
// Purpose: bring raw ps2_clk/ps2_data into the clk domain, debounce ps2_clk and
//          flag each filtered falling edge.
// Ports:   clk, rst (async, active-high)
//          ps2_clk, ps2_data : raw asynchronous bus lines
//          fall              : one-cycle pulse on filtered ps2_clk 1->0
//          data_s            : synchronised ps2_data
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with clk_filt;
  // any agreeing sample restarts the run, so short glitches never get through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      cnt        <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign fall   = clk_filt_d & ~clk_filt;
  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host 11-bit frame receiver
//
// Purpose: deserialise PS/2 frames, check start/parity/stop and report bytes.
// Ports:   clk, rst (async, active-high)
//          ps2_clk, ps2_data : raw PS/2 lines
//          key_in[7:0]       : last good byte, held until the next good frame
//          valid             : pulse, key_in updated with an ordinary byte
//          is_extend         : pulse, good 0xE0 received
//          is_break          : pulse, good 0xF0 received
//          err               : pulse, bad parity/stop or inter-bit timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       valid,
  output logic       is_extend,
  output logic       is_break,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall;
  logic          data_s;
  ps2_state_t    state;
  ps2_state_t    state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic          stop_bit;
  logic [TW-1:0] to_cnt;
  logic          in_frame;
  logic          timeout;
  logic          frame_ok;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .data_s  (data_s)
  );

  assign in_frame = (state == DATA) || (state == PARITY) || (state == STOP);
  assign timeout  = in_frame && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok = odd_parity_ok(shreg, parity_bit) && stop_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Timeout takes priority over a coincident fall so an aborted frame never
  // advances into CHECK.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall && !data_s) state_nxt = DATA;
      DATA:    if (timeout) state_nxt = IDLE;
               else if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY:  if (timeout) state_nxt = IDLE;
               else if (fall) state_nxt = STOP;
      STOP:    if (timeout) state_nxt = IDLE;
               else if (fall) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      stop_bit   <= 1'b0;
      to_cnt     <= '0;
      key_in     <= '0;
      valid      <= 1'b0;
      is_extend  <= 1'b0;
      is_break   <= 1'b0;
      err        <= 1'b0;
    end else begin
      valid     <= 1'b0;
      is_extend <= 1'b0;
      is_break  <= 1'b0;
      err       <= timeout;

      if (in_frame && !fall) to_cnt <= to_cnt + TW'(1);
      else                   to_cnt <= '0;

      case (state)
        IDLE: bit_cnt <= '0;
        DATA: if (fall) begin
          // LSB arrives first, so shifting right leaves d0 in bit 0.
          shreg   <= {data_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY: if (fall) parity_bit <= data_s;
        STOP:   if (fall) stop_bit <= data_s;
        CHECK: begin
          if (frame_ok) begin
            key_in <= shreg;
            if (shreg == PS2_EXTEND)     is_extend <= 1'b1;
            else if (shreg == PS2_BREAK) is_break  <= 1'b1;
            else                         valid     <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - scoreboard bench for ps2_frame_rx
module tb_ps2_frame_rx;

  localparam int FL      = 4;
  localparam int TMO     = 2000;
  localparam int HALF    = 20;
  localparam int GAP     = 60;
  localparam int K_VALID = 0;
  localparam int K_EXT   = 1;
  localparam int K_BRK   = 2;
  localparam int K_ERR   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_in;
  logic       valid, is_extend, is_break, err;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_in   (key_in),
    .valid    (valid),
    .is_extend(is_extend),
    .is_break (is_break),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] key;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] key_model = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the frame bits themselves:
  // f[0]=start, f[8:1]=byte LSB first, f[9]=parity, f[10]=stop.
  function automatic exp_t predict(input logic [10:0] f);
    exp_t e;
    logic [7:0] b;
    b = f[8:1];
    if (($countones(f[9:1]) % 2 == 1) && f[10] == 1'b1) begin
      key_model = b;
      if (b == 8'hE0)      e.kind = K_EXT;
      else if (b == 8'hF0) e.kind = K_BRK;
      else                 e.kind = K_VALID;
    end else begin
      e.kind = K_ERR;
    end
    e.key = key_model;
    e.due = -1;
    return e;
  endfunction

  // Drives the first nbits of f; on the stop-bit fall, queues the expectation.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch, input bit push);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch && i > 0) begin
        cycles(HALF / 4);
        ps2_clk = 1'b0;
        cycles(2);
        ps2_clk = 1'b1;
        cycles(HALF - HALF / 4 - 2);
      end else begin
        cycles(HALF);
      end
      ps2_clk = 1'b0;
      if (push && i == 10) begin
        e = predict(f);
        e.due = cyc + FL + 4;
        sb.push_back(e);
      end
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(GAP);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic p;
    p = ($countones(b) % 2 == 0);
    if (par_bad) p = ~p;
    return {~stop_bad, p, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad, input bit glitch);
    send_bits(make_frame(b, par_bad, stop_bad), 11, glitch, 1'b1);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    int   n;
    if (!rst && (valid | is_extend | is_break | err)) begin
      n = int'(valid) + int'(is_extend) + int'(is_break) + int'(err);
      chk(n == 1, "exclusive_pulses", n, 1);
      kind = valid ? K_VALID : is_extend ? K_EXT : is_break ? K_BRK : K_ERR;
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_pulse", kind, -1);
      end else begin
        e = sb.pop_front();
        chk(kind == e.kind, "pulse_kind", kind, e.kind);
        chk(key_in == e.key, "key_in", int'(key_in), int'(e.key));
        if (e.due >= 0) chk(cyc == e.due, "pulse_latency", cyc, e.due);
      end
    end
  end

  initial begin
    exp_t       e;
    logic [7:0] b;
    int         sel;
    int         bound;

    #2;
    chk(key_in == 8'h00, "reset_key_in", int'(key_in), 0);
    chk(valid == 1'b0, "reset_valid", int'(valid), 0);
    chk(is_extend == 1'b0, "reset_is_extend", int'(is_extend), 0);
    chk(is_break == 1'b0, "reset_is_break", int'(is_break), 0);
    chk(err == 1'b0, "reset_err", int'(err), 0);
    cycles(5);
    rst = 1'b0;
    cycles(10);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1B, 1'b1, 1'b0, 1'b0);

    // Start plus four data bits, then silence until the timeout fires.
    e.kind = K_ERR;
    e.key  = key_model;
    e.due  = -1;
    sb.push_back(e);
    send_bits(make_frame(8'h55, 1'b0, 1'b0), 5, 1'b0, 1'b0);
    cycles(TMO + 200);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0);

    send_frame(8'h3A, 1'b0, 1'b0, 1'b1);
    // Idle glitch and a clean idle fall with data high: neither may report.
    ps2_clk = 1'b0; cycles(2); ps2_clk = 1'b1; cycles(GAP);
    ps2_clk = 1'b0; cycles(HALF); ps2_clk = 1'b1; cycles(GAP);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);

    // Reset after start plus five data bits.
    send_bits(make_frame(8'h77, 1'b0, 1'b0), 6, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk(key_in == 8'h00, "midreset_key_in", int'(key_in), 0);
    chk({valid, is_extend, is_break, err} == 4'b0, "midreset_pulses",
        int'({valid, is_extend, is_break, err}), 0);
    key_model = 8'h00;
    cycles(5);
    rst = 1'b0;
    cycles(10);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_frame(b, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1);
    end

    bound = 0;
    while (sb.size() != 0 && bound < 1000) begin
      cycles(1);
      bound++;
    end
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
